// File: rtl/boot_loader_ctrl_if.sv
// Bus bundle between the UART byte receiver, the boot loader controller and
// the instruction ROM write port. The master side is the controller.
interface boot_loader_ctrl_if #(
    parameter int ADDR_W = 8
) ();
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rom_we;
    logic [ADDR_W-1:0] rom_addr;
    logic [31:0]       rom_wdata;
    logic              cpu_enable;
    logic              busy;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    modport master (
        input  rx_valid, rx_data,
        output rom_we, rom_addr, rom_wdata, cpu_enable, busy, error, words_loaded
    );

    modport slave (
        output rx_valid, rx_data,
        input  rom_we, rom_addr, rom_wdata, cpu_enable, busy, error, words_loaded
    );
endinterface

// File: rtl/boot_loader_ctrl.sv
// Boot loader controller: parses sync / length / little-endian words / checksum
// frames from the UART byte stream, writes each assembled word into the
// instruction ROM and lets the CPU run only after a frame whose checksum matches.
module boot_loader_ctrl #(
    parameter int         ADDR_W         = 8,
    parameter int         TIMEOUT_CYCLES = 2700000,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
    input logic                clk,
    input logic                reset,
    boot_loader_ctrl_if.master bus
);
    localparam int                 TIMER_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0]        MAX_LEN    = 17'(2 ** ADDR_W);

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CHECK,
        RUN,
        ERROR
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [15:0]        len;
    logic [1:0]         byte_idx;
    logic [23:0]        word_buf;
    logic [7:0]         sum8;
    logic [TIMER_W-1:0] timer;

    logic               is_sync;
    logic               expired;
    logic               last_word;
    logic               in_frame_nxt;
    logic [15:0]        len_rx;

    // Next-state decode: frame parsing, checksum verdict and inter-byte timeout.
    // A byte arriving on the expiry cycle wins, so expiry is masked by rx_valid.
    always_comb begin
        state_nxt = state;
        is_sync   = bus.rx_valid && (bus.rx_data == SYNC_BYTE);
        expired   = !bus.rx_valid && (timer == TIMER_LAST);
        len_rx    = {bus.rx_data, len[7:0]};
        last_word = ((17'(bus.words_loaded) + 17'd1) == {1'b0, len});

        case (state)
            IDLE, RUN, ERROR: begin
                if (is_sync) state_nxt = LEN_LO;
            end
            LEN_LO: begin
                if (bus.rx_valid)  state_nxt = LEN_HI;
                else if (expired)  state_nxt = ERROR;
            end
            LEN_HI: begin
                if (bus.rx_valid) begin
                    if ({1'b0, len_rx} > MAX_LEN) state_nxt = ERROR;
                    else if (len_rx == 16'd0)     state_nxt = CHECK;
                    else                          state_nxt = DATA;
                end else if (expired) begin
                    state_nxt = ERROR;
                end
            end
            DATA: begin
                // Leave only once the final word's strobe has been counted.
                if (bus.rom_we && last_word) state_nxt = CHECK;
                else if (expired)            state_nxt = ERROR;
            end
            CHECK: begin
                if (bus.rx_valid)  state_nxt = (bus.rx_data == sum8) ? RUN : ERROR;
                else if (expired)  state_nxt = ERROR;
            end
            default: state_nxt = IDLE;
        endcase

        in_frame_nxt = (state_nxt == LEN_LO) || (state_nxt == LEN_HI) ||
                       (state_nxt == DATA)   || (state_nxt == CHECK);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Datapath and registered outputs: length capture, word assembly, checksum,
    // ROM strobe/address/count, inter-byte timer and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len              <= '0;
            byte_idx         <= '0;
            word_buf         <= '0;
            sum8             <= '0;
            timer            <= '0;
            bus.rom_we       <= 1'b0;
            bus.rom_addr     <= '0;
            bus.rom_wdata    <= '0;
            bus.cpu_enable   <= 1'b0;
            bus.busy         <= 1'b0;
            bus.error        <= 1'b0;
            bus.words_loaded <= '0;
        end else begin
            bus.rom_we     <= 1'b0;
            bus.cpu_enable <= (state_nxt == RUN);
            bus.error      <= (state_nxt == ERROR);
            bus.busy       <= in_frame_nxt;

            if (bus.rx_valid || !in_frame_nxt) timer <= '0;
            else                               timer <= timer + 1'b1;

            if ((state != LEN_LO) && (state_nxt == LEN_LO)) begin
                sum8     <= '0;
                byte_idx <= '0;
            end

            case (state)
                LEN_LO: begin
                    if (bus.rx_valid) len[7:0] <= bus.rx_data;
                end
                LEN_HI: begin
                    if (bus.rx_valid) begin
                        len[15:8] <= bus.rx_data;
                        if ({1'b0, len_rx} <= MAX_LEN) begin
                            bus.rom_addr     <= '0;
                            bus.words_loaded <= '0;
                        end
                    end
                end
                DATA: begin
                    if (bus.rx_valid) begin
                        sum8     <= sum8 + bus.rx_data;
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0:    word_buf[7:0]   <= bus.rx_data;
                            2'd1:    word_buf[15:8]  <= bus.rx_data;
                            2'd2:    word_buf[23:16] <= bus.rx_data;
                            default: begin
                                bus.rom_wdata <= {bus.rx_data, word_buf};
                                bus.rom_we    <= 1'b1;
                            end
                        endcase
                    end
                    // Address holds during the strobe and advances right after it.
                    if (bus.rom_we) begin
                        bus.rom_addr     <= bus.rom_addr + 1'b1;
                        bus.words_loaded <= bus.words_loaded + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Testbench for boot_loader_ctrl: frame-level reference model, fixed scenarios
// and randomized frames, with a monitor collecting every ROM write.
`timescale 1ns/1ps
module tb_boot_loader_ctrl;
    localparam int ADDR_W = 8;
    localparam int TMO    = 100;

    typedef logic [7:0] bq_t[$];

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    boot_loader_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    boot_loader_ctrl #(
        .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO), .SYNC_BYTE(8'hA5)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    logic [39:0] got_wr[$];
    logic [39:0] exp_wr[$];
    logic        exp_cpu;
    logic        exp_err;
    int          exp_words;
    bit          prev_we;
    bit          we_double;
    bit          we_outside;

    // Record every ROM write and flag back-to-back or out-of-frame strobes.
    always @(negedge clk) begin
        if (bus.rom_we) begin
            got_wr.push_back({bus.rom_addr, bus.rom_wdata});
            if (prev_we)   we_double  = 1'b1;
            if (!bus.busy) we_outside = 1'b1;
        end
        prev_we = bus.rom_we;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    // Frame-level reference: decode the whole frame and predict the ROM writes
    // and the resulting status.
    task automatic model_frame(input bq_t fr);
        int          len;
        logic [7:0]  s;
        logic [31:0] w;
        exp_wr.delete();
        len = int'(fr[1]) + 256 * int'(fr[2]);
        if (len > (1 << ADDR_W)) begin
            exp_cpu = 1'b0;
            exp_err = 1'b1;
            return;
        end
        exp_words = len;
        s = 8'h00;
        for (int i = 0; i < len; i++) begin
            w = {fr[6 + 4*i], fr[5 + 4*i], fr[4 + 4*i], fr[3 + 4*i]};
            s = s + fr[3 + 4*i] + fr[4 + 4*i] + fr[5 + 4*i] + fr[6 + 4*i];
            exp_wr.push_back({8'(i), w});
        end
        exp_cpu = (fr[3 + 4*len] == s);
        exp_err = !exp_cpu;
    endtask

    function automatic bq_t make_frame(input int len, input bit bad);
        bq_t        fr;
        logic [7:0] s;
        logic [7:0] b;
        s = 8'h00;
        fr.push_back(8'hA5);
        fr.push_back(8'(len));
        fr.push_back(8'(len >> 8));
        if (len <= (1 << ADDR_W)) begin
            for (int i = 0; i < 4*len; i++) begin
                b = 8'($urandom);
                fr.push_back(b);
                s = s + b;
            end
            fr.push_back(bad ? (s ^ 8'($urandom_range(1, 255))) : s);
        end
        return fr;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_frame(input bq_t fr);
        got_wr.delete();
        we_double  = 1'b0;
        we_outside = 1'b0;
        foreach (fr[i]) send_byte(fr[i]);
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({bus.rom_we, bus.rom_addr, bus.rom_wdata, bus.cpu_enable, bus.busy,
             bus.error, bus.words_loaded} !== 53'd0) begin
            errors++;
            $display("FAIL reset_outputs got we=%0b addr=%0h wdata=%0h cpu=%0b busy=%0b err=%0b words=%0d exp all 0",
                     bus.rom_we, bus.rom_addr, bus.rom_wdata, bus.cpu_enable, bus.busy, bus.error, bus.words_loaded);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        send_byte(8'h33);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignores_byte busy got %0b exp 0", bus.busy);
        end
    endtask

    task automatic test_good_frame();
        bq_t fr;
        fr = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
               8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h4C};
        send_frame(fr);
        checks++;
        if (got_wr.size() !== 2) begin
            errors++;
            $display("FAIL good_write_count got %0d exp 2", got_wr.size());
        end else begin
            checks++;
            if (got_wr[0] !== {8'h00, 32'h12345678}) begin
                errors++;
                $display("FAIL good_write0 got %0h exp %0h", got_wr[0], {8'h00, 32'h12345678});
            end
            checks++;
            if (got_wr[1] !== {8'h01, 32'hDEADBEEF}) begin
                errors++;
                $display("FAIL good_write1 got %0h exp %0h", got_wr[1], {8'h01, 32'hDEADBEEF});
            end
        end
        checks++;
        if ({bus.cpu_enable, bus.error, bus.busy} !== 3'b100) begin
            errors++;
            $display("FAIL good_status cpu/err/busy got %03b exp 100",
                     {bus.cpu_enable, bus.error, bus.busy});
        end
        checks++;
        if (bus.words_loaded !== 9'd2) begin
            errors++;
            $display("FAIL good_words got %0d exp 2", bus.words_loaded);
        end
    endtask

    task automatic test_bad_checksum();
        bq_t fr;
        fr = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
               8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h4D};
        send_frame(fr);
        checks++;
        if (got_wr.size() !== 2) begin
            errors++;
            $display("FAIL bad_write_count got %0d exp 2", got_wr.size());
        end
        checks++;
        if ({bus.cpu_enable, bus.error} !== 2'b01) begin
            errors++;
            $display("FAIL bad_status cpu/err got %02b exp 01", {bus.cpu_enable, bus.error});
        end
        send_byte(8'hA5);
        checks++;
        if ({bus.error, bus.busy} !== 2'b01) begin
            errors++;
            $display("FAIL bad_resync err/busy got %02b exp 01", {bus.error, bus.busy});
        end
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
    endtask

    task automatic test_oversize();
        send_frame('{8'hA5, 8'h01, 8'h01});
        checks++;
        if ({bus.error, bus.busy, bus.cpu_enable} !== 3'b100) begin
            errors++;
            $display("FAIL oversize_status err/busy/cpu got %03b exp 100",
                     {bus.error, bus.busy, bus.cpu_enable});
        end
        checks++;
        if (got_wr.size() !== 0) begin
            errors++;
            $display("FAIL oversize_writes got %0d exp 0", got_wr.size());
        end
    endtask

    task automatic test_zero_length();
        send_frame('{8'hA5, 8'h00, 8'h00, 8'h00});
        checks++;
        if ({bus.cpu_enable, bus.error, bus.busy} !== 3'b100) begin
            errors++;
            $display("FAIL zero_status cpu/err/busy got %03b exp 100",
                     {bus.cpu_enable, bus.error, bus.busy});
        end
        checks++;
        if (bus.words_loaded !== 9'd0 || got_wr.size() !== 0) begin
            errors++;
            $display("FAIL zero_words words got %0d writes got %0d exp 0 and 0",
                     bus.words_loaded, got_wr.size());
        end
    endtask

    task automatic test_timeout();
        int first_n;
        first_n = -1;
        send_frame('{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22});
        for (int n = 1; n <= 2*TMO; n++) begin
            @(posedge clk); #1;
            if (bus.error && first_n < 0) first_n = n;
        end
        checks++;
        if (first_n !== TMO) begin
            errors++;
            $display("FAIL timeout_cycles got %0d exp %0d", first_n, TMO);
        end
        checks++;
        if ({bus.cpu_enable, bus.busy} !== 2'b00 || got_wr.size() !== 0) begin
            errors++;
            $display("FAIL timeout_status cpu/busy got %02b writes %0d exp 00 and 0",
                     {bus.cpu_enable, bus.busy}, got_wr.size());
        end
    endtask

    task automatic test_reload();
        bq_t fr;
        fr = make_frame($urandom_range(1, 3), 1'b0);
        model_frame(fr);
        send_frame(fr);
        checks++;
        if (bus.cpu_enable !== exp_cpu) begin
            errors++;
            $display("FAIL reload_run cpu got %0b exp %0b", bus.cpu_enable, exp_cpu);
        end
        send_byte(8'hA5);
        checks++;
        if ({bus.cpu_enable, bus.busy} !== 2'b01) begin
            errors++;
            $display("FAIL reload_drop cpu/busy got %02b exp 01", {bus.cpu_enable, bus.busy});
        end
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
    endtask

    task automatic test_max_length();
        bq_t fr;
        fr = make_frame(1 << ADDR_W, 1'b0);
        model_frame(fr);
        send_frame(fr);
        checks++;
        if (got_wr != exp_wr) begin
            errors++;
            $display("FAIL maxlen_writes got %0d writes exp %0d", got_wr.size(), exp_wr.size());
        end
        checks++;
        if (bus.words_loaded !== 9'(exp_words) || bus.cpu_enable !== exp_cpu) begin
            errors++;
            $display("FAIL maxlen_status words got %0d exp %0d cpu got %0b exp %0b",
                     bus.words_loaded, exp_words, bus.cpu_enable, exp_cpu);
        end
    endtask

    task automatic test_random_frames();
        bq_t fr;
        int  len;
        for (int k = 0; k < 10; k++) begin
            len = ($urandom_range(0, 5) == 0) ? $urandom_range(257, 400) : $urandom_range(0, 6);
            fr  = make_frame(len, $urandom_range(0, 2) == 0);
            model_frame(fr);
            send_frame(fr);
            checks++;
            if (got_wr.size() !== exp_wr.size()) begin
                errors++;
                $display("FAIL rand%0d_write_count got %0d exp %0d", k, got_wr.size(), exp_wr.size());
            end else begin
                foreach (exp_wr[i]) begin
                    checks++;
                    if (got_wr[i] !== exp_wr[i]) begin
                        errors++;
                        $display("FAIL rand%0d_write%0d got %0h exp %0h", k, i, got_wr[i], exp_wr[i]);
                    end
                end
            end
            checks++;
            if ({bus.cpu_enable, bus.error, bus.busy} !== {exp_cpu, exp_err, 1'b0}) begin
                errors++;
                $display("FAIL rand%0d_status cpu/err/busy got %03b exp %03b", k,
                         {bus.cpu_enable, bus.error, bus.busy}, {exp_cpu, exp_err, 1'b0});
            end
            checks++;
            if (bus.words_loaded !== 9'(exp_words)) begin
                errors++;
                $display("FAIL rand%0d_words got %0d exp %0d", k, bus.words_loaded, exp_words);
            end
            checks++;
            if (we_double || we_outside) begin
                errors++;
                $display("FAIL rand%0d_strobe double=%0b outside=%0b exp 0 0", k, we_double, we_outside);
            end
        end
    endtask

    task automatic test_reset_mid_data();
        send_frame('{8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05});
        checks++;
        if ({bus.busy, bus.words_loaded, bus.rom_addr} !== {1'b1, 9'd1, 8'd1}) begin
            errors++;
            $display("FAIL middata_progress busy got %0b words %0d addr %0d exp 1 1 1",
                     bus.busy, bus.words_loaded, bus.rom_addr);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({bus.rom_we, bus.rom_addr, bus.rom_wdata, bus.cpu_enable, bus.busy,
             bus.error, bus.words_loaded} !== 53'd0) begin
            errors++;
            $display("FAIL middata_async_reset got we=%0b addr=%0h wdata=%0h cpu=%0b busy=%0b err=%0b words=%0d exp all 0",
                     bus.rom_we, bus.rom_addr, bus.rom_wdata, bus.cpu_enable, bus.busy, bus.error, bus.words_loaded);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        send_byte(8'h00);
        checks++;
        if ({bus.busy, bus.error, bus.cpu_enable} !== 3'b000) begin
            errors++;
            $display("FAIL middata_idle busy/err/cpu got %03b exp 000",
                     {bus.busy, bus.error, bus.cpu_enable});
        end
        send_byte(8'hA5);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL middata_resync busy got %0b exp 1", bus.busy);
        end
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        exp_words    = 0;
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_oversize();
        test_zero_length();
        test_timeout();
        test_reload();
        test_max_length();
        test_random_frames();
        test_reset_mid_data();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
